// File: rtl/div512_ss_pkg.sv
// div512_ss shared package: default widths, FSM state type and
// the iteration counter width used by the restoring divider.
package div512_ss_pkg;

    localparam int NW_DEF = 512;
    localparam int DW_DEF = 256;
    localparam int CNT_W  = $clog2(NW_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DONE_Z = 2'd2,
        FIN    = 2'd3
    } state_e;

endpackage

// File: rtl/div512_ss_sub_cla.sv
// sub_cla: W-bit parallel-prefix carry-lookahead subtractor, diff = a - b.
// Ports: a, b (operands), diff (a - b mod 2^W), borrow (1 when a < b).
module sub_cla #(
    parameter int W = 257
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    localparam int L = $clog2(W);

    // a - b is computed as a + ~b + 1; level 0 holds per-bit
    // generate/propagate, each further level doubles the prefix span.
    for (genvar k = 0; k <= L; k++) begin : lvl
        logic [W-1:0] g;
        logic [W-1:0] p;
        if (k == 0) begin : g_base
            assign g = a & ~b;
            assign p = a ^ ~b;
        end else begin : g_pfx
            localparam int S = 1 << (k - 1);
            assign g = lvl[k-1].g
                     | (lvl[k-1].p & {lvl[k-1].g[W-S-1:0], {S{1'b0}}});
            assign p = lvl[k-1].p & {lvl[k-1].p[W-S-1:0], {S{1'b1}}};
        end
    end

    // Carry-in of 1 folds into every prefix as G | P.
    logic [W-1:0] c;
    assign c      = {lvl[L].g[W-2:0] | lvl[L].p[W-2:0], 1'b1};
    assign diff   = lvl[0].p ^ c;
    assign borrow = ~(lvl[L].g[W-1] | lvl[L].p[W-1]);

endmodule

// File: rtl/div512_ss.sv
// div512_ss: sequential unsigned restoring divider, one quotient bit per
// enabled clock. Ports: clk, rst_n (async, active-low), en (clock enable),
// start/dividend/divisor (request), busy, done (1-cycle pulse),
// div_by_zero, quotient, remainder (registered results).
module div512_ss
    import div512_ss_pkg::*;
#(
    parameter int NW = NW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          start,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero,
    output logic [NW-1:0] quotient,
    output logic [DW-1:0] remainder
);

    localparam int CW = $clog2(NW);

    if (DW >= NW) begin : g_bad_width
        $error("div512_ss: DW must be smaller than NW");
    end

    state_e        state_q, state_d;
    logic [NW-1:0] dvd_q;
    logic [DW-1:0] dsr_q;
    logic [DW:0]   rem_q;
    logic [CW-1:0] cnt_q;
    logic [NW-1:0] quo_q;
    logic [DW-1:0] rmd_q;
    logic          done_q;
    logic          dbz_q;

    // Partial remainder stays below the divisor, so its MSB is always 0
    // before a shift; only DW bits feed the next step.
    logic [DW:0] shifted;
    logic [DW:0] trial;
    logic        brw;
    logic        unused_rem_msb;

    assign shifted        = {rem_q[DW-1:0], dvd_q[NW-1]};
    assign unused_rem_msb = rem_q[DW];

    sub_cla #(
        .W(DW + 1)
    ) u_sub (
        .a     (shifted),
        .b     ({1'b0, dsr_q}),
        .diff  (trial),
        .borrow(brw)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (divisor == '0) ? DONE_Z : RUN;
                end
            end
            RUN: begin
                if (cnt_q == CW'(NW - 1)) begin
                    state_d = FIN;
                end
            end
            DONE_Z:  state_d = IDLE;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        unique case (state_q)
            RUN:     busy = 1'b1;
            DONE_Z:  busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Datapath. The dividend register doubles as the quotient shifter:
    // its MSB is consumed each step while the new quotient bit enters
    // at the LSB, so after NW steps it holds the full quotient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q  <= '0;
            dsr_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rmd_q  <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else if (en) begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        dvd_q <= dividend;
                        dsr_q <= divisor;
                        rem_q <= '0;
                        cnt_q <= '0;
                        dbz_q <= 1'b0;
                    end
                end
                RUN: begin
                    rem_q <= brw ? shifted : trial;
                    dvd_q <= {dvd_q[NW-2:0], ~brw};
                    cnt_q <= cnt_q + 1'b1;
                end
                FIN: begin
                    quo_q  <= dvd_q;
                    rmd_q  <= rem_q[DW-1:0];
                    done_q <= 1'b1;
                end
                DONE_Z: begin
                    quo_q  <= '1;
                    rmd_q  <= dvd_q[DW-1:0];
                    dbz_q  <= 1'b1;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;

endmodule

// File: tb/tb_div512_ss.sv
// tb_div512_ss: self-checking bench for div512_ss; random operands are
// compared against plain '/' and '%' arithmetic.
module tb_div512_ss;

    localparam int NW = 512;
    localparam int DW = 256;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          en       = 1'b1;
    logic          start    = 1'b0;
    logic [NW-1:0] dividend = '0;
    logic [DW-1:0] divisor  = '0;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [NW-1:0] quotient;
    logic [DW-1:0] remainder;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    div512_ss #(.NW(NW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    function automatic logic [NW-1:0] mq(input logic [NW-1:0] a,
                                         input logic [DW-1:0] b);
        logic [NW-1:0] bw;
        bw = NW'(b);
        if (b == '0) return '1;
        return a / bw;
    endfunction

    function automatic logic [DW-1:0] mr(input logic [NW-1:0] a,
                                         input logic [DW-1:0] b);
        logic [NW-1:0] bw;
        bw = NW'(b);
        if (b == '0) return a[DW-1:0];
        return DW'(a % bw);
    endfunction

    function automatic logic [NW-1:0] rnd_nw();
        logic [NW-1:0] r;
        for (int i = 0; i < NW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_dw(input int bits);
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        r = r >> (DW - bits);
        r[bits-1] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [NW-1:0] a, input logic [DW-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        en       = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Counts enabled edges until done is seen; bounded by total edges.
    task automatic wait_done(input bit rnd_en, output int cyc, output bit ok);
        int edges;
        edges = 0;
        cyc   = 0;
        ok    = 1'b0;
        while (edges < 4000 && !done) begin
            en = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            edges++;
            if (en) cyc++;
        end
        ok = done;
        en = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        chk_cnt++;
        if ({busy, done, div_by_zero} !== 3'b000)
            $display("FAIL reset_flags got=%b exp=000", {busy, done, div_by_zero});
        else pass_cnt++;
        chk_cnt++;
        if (quotient !== '0 || remainder !== '0)
            $display("FAIL reset_data got q=%h r=%h exp 0", quotient, remainder);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int cyc;
        bit ok;
        go(100, 7);
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL basic_busy got=%b exp=1", busy);
        else pass_cnt++;
        wait_done(1'b0, cyc, ok);
        chk_cnt++;
        if (!ok || cyc != NW + 1)
            $display("FAIL basic_latency got=%0d ok=%b exp=%0d", cyc, ok, NW + 1);
        else pass_cnt++;
        chk_cnt++;
        if (quotient !== NW'(14) || remainder !== DW'(2) || div_by_zero !== 1'b0)
            $display("FAIL basic_result got q=%0d r=%0d z=%b exp q=14 r=2 z=0",
                     quotient, remainder, div_by_zero);
        else pass_cnt++;
        tick();
        tick();
        chk_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== NW'(14))
            $display("FAIL basic_hold got done=%b busy=%b q=%0d exp 0 0 14",
                     done, busy, quotient);
        else pass_cnt++;
    endtask

    task automatic test_boundary();
        int cyc;
        bit ok;
        logic [NW-1:0] ones;
        ones = '1;
        go(ones, 1);
        wait_done(1'b0, cyc, ok);
        chk_cnt++;
        if (!ok || quotient !== ones || remainder !== '0)
            $display("FAIL bnd_ones_div1 got q=%h r=%h ok=%b", quotient, remainder, ok);
        else pass_cnt++;
        go(5, 9);
        wait_done(1'b0, cyc, ok);
        chk_cnt++;
        if (!ok || quotient !== '0 || remainder !== DW'(5))
            $display("FAIL bnd_5_div9 got q=%0d r=%0d exp q=0 r=5", quotient, remainder);
        else pass_cnt++;
    endtask

    task automatic test_div_zero();
        int cyc;
        bit ok;
        go(NW'(16'h1234), '0);
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL dz_busy got=%b exp=1", busy);
        else pass_cnt++;
        wait_done(1'b0, cyc, ok);
        chk_cnt++;
        if (!ok || cyc != 1) $display("FAIL dz_latency got=%0d exp=1", cyc);
        else pass_cnt++;
        chk_cnt++;
        if (quotient !== {NW{1'b1}} || remainder !== DW'(16'h1234) || div_by_zero !== 1'b1)
            $display("FAIL dz_result got q=%h r=%h z=%b exp all-ones 1234 1",
                     quotient, remainder, div_by_zero);
        else pass_cnt++;
        go(rnd_nw(), rnd_dw(40));
        chk_cnt++;
        if (div_by_zero !== 1'b0) $display("FAIL dz_clear got=%b exp=0", div_by_zero);
        else pass_cnt++;
        wait_done(1'b0, cyc, ok);
    endtask

    task automatic test_random();
        int cyc;
        bit ok;
        int widths[6] = '{1, 8, 33, 128, 200, 256};
        logic [NW-1:0] a;
        logic [DW-1:0] b;
        for (int i = 0; i < 6; i++) begin
            a = rnd_nw();
            b = rnd_dw(widths[i]);
            go(a, b);
            wait_done(1'b0, cyc, ok);
            chk_cnt++;
            if (!ok || cyc != NW + 1 || quotient !== mq(a, b) || remainder !== mr(a, b))
                $display("FAIL rand_%0d got q=%h r=%h cyc=%0d exp q=%h r=%h",
                         i, quotient, remainder, cyc, mq(a, b), mr(a, b));
            else pass_cnt++;
        end
    endtask

    task automatic test_restart_ignored();
        int cyc;
        bit ok;
        logic [NW-1:0] a;
        logic [DW-1:0] b;
        a = rnd_nw();
        b = rnd_dw(100);
        go(a, b);
        for (int i = 0; i < 99; i++) tick();
        dividend = rnd_nw();
        divisor  = rnd_dw(20);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL restart_busy got=%b exp=1", busy);
        else pass_cnt++;
        wait_done(1'b0, cyc, ok);
        chk_cnt++;
        if (!ok || cyc != NW + 1 - 100)
            $display("FAIL restart_latency got=%0d exp=%0d", cyc, NW + 1 - 100);
        else pass_cnt++;
        chk_cnt++;
        if (quotient !== mq(a, b) || remainder !== mr(a, b))
            $display("FAIL restart_result got q=%h r=%h exp q=%h r=%h",
                     quotient, remainder, mq(a, b), mr(a, b));
        else pass_cnt++;
    endtask

    task automatic test_en_toggle();
        int cyc;
        bit ok;
        logic [NW-1:0] a;
        logic [DW-1:0] b;
        a = rnd_nw();
        b = rnd_dw(150);
        go(a, b);
        wait_done(1'b1, cyc, ok);
        chk_cnt++;
        if (!ok || cyc != NW + 1)
            $display("FAIL en_latency got=%0d ok=%b exp=%0d", cyc, ok, NW + 1);
        else pass_cnt++;
        chk_cnt++;
        if (quotient !== mq(a, b) || remainder !== mr(a, b))
            $display("FAIL en_result got q=%h r=%h exp q=%h r=%h",
                     quotient, remainder, mq(a, b), mr(a, b));
        else pass_cnt++;
        en = 1'b0;
        tick();
        tick();
        chk_cnt++;
        if (done !== 1'b1) $display("FAIL en_done_freeze got=%b exp=1", done);
        else pass_cnt++;
        en = 1'b1;
        tick();
        chk_cnt++;
        if (done !== 1'b0) $display("FAIL en_done_release got=%b exp=0", done);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int seen;
        bit ok;
        go(rnd_nw(), rnd_dw(64));
        for (int i = 0; i < 299; i++) tick();
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0)
            $display("FAIL rst_mid got busy=%b done=%b z=%b q=%h r=%h exp all 0",
                     busy, done, div_by_zero, quotient, remainder);
        else pass_cnt++;
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (done) seen++;
        end
        chk_cnt++;
        if (seen != 0 || busy !== 1'b0)
            $display("FAIL rst_abort got done_pulses=%0d busy=%b exp 0 0", seen, busy);
        else pass_cnt++;
        go(1000, 10);
        wait_done(1'b0, cyc, ok);
        chk_cnt++;
        if (!ok || cyc != NW + 1 || quotient !== NW'(100) || remainder !== '0)
            $display("FAIL rst_fresh got q=%0d r=%0d cyc=%0d exp q=100 r=0 cyc=%0d",
                     quotient, remainder, cyc, NW + 1);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit ok;
        logic [NW-1:0] a1, a2;
        logic [DW-1:0] b1, b2;
        a1 = rnd_nw();
        b1 = rnd_dw(250);
        a2 = rnd_nw();
        b2 = rnd_dw(12);
        go(a1, b1);
        wait_done(1'b0, cyc, ok);
        chk_cnt++;
        if (!ok || quotient !== mq(a1, b1) || remainder !== mr(a1, b1))
            $display("FAIL b2b_first got q=%h r=%h exp q=%h r=%h",
                     quotient, remainder, mq(a1, b1), mr(a1, b1));
        else pass_cnt++;
        go(a2, b2);
        chk_cnt++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_accept got busy=%b done=%b exp 1 0", busy, done);
        else pass_cnt++;
        wait_done(1'b0, cyc, ok);
        chk_cnt++;
        if (!ok || cyc != NW + 1 || quotient !== mq(a2, b2) || remainder !== mr(a2, b2))
            $display("FAIL b2b_second got q=%h r=%h cyc=%0d exp q=%h r=%h",
                     quotient, remainder, cyc, mq(a2, b2), mr(a2, b2));
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_div_zero();
        test_random();
        test_restart_ignored();
        test_en_toggle();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/div512_ss.md
DIV512_SS -- requirements
Module: div512_ss

Interface
REQ-001 Parameter NW, default 512, dividend and quotient width.
REQ-002 Parameter DW, default 256, divisor and remainder width; the design SHALL require DW < NW.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset: asynchronous, active-low.
REQ-005 en  input  1  clock enable; when low, all state SHALL hold.
REQ-006 start  input  1  request a division; sampled only when en=1 and state is IDLE.
REQ-007 dividend  input  NW  numerator, unsigned; captured when start is accepted.
REQ-008 divisor  input  DW  denominator, unsigned; captured when start is accepted.
REQ-009 busy  output  1  high in RUN and DONE_Z states.
REQ-010 done  output  1  one-cycle result-valid pulse.
REQ-011 div_by_zero  output  1  error flag for the last completed operation.
REQ-012 quotient  output  NW  result, registered.
REQ-013 remainder  output  DW  result, registered.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DONE_Z and FIN, encoded in 2 bits.
REQ-015 IDLE: if en=1 and start=1, the block SHALL latch operands, clear the partial remainder (DW+1 bits) and the 9-bit iteration counter, clear done and div_by_zero, and go to RUN when divisor!=0 or DONE_Z when divisor==0.
REQ-016 RUN: each en cycle SHALL perform one restoring step.
  - Shift the partial remainder left 1 and insert the current dividend MSB.
  - Trial-subtract the latched divisor.
  - If there is no borrow, keep the difference and shift quotient bit 1 in; otherwise keep the shifted value and shift 0 in.
  - Shift the dividend register left 1 and increment the counter.
REQ-017 RUN SHALL last exactly NW en-cycles; on the step where counter==NW-1 the block SHALL go to FIN.
REQ-018 FIN: the block SHALL load quotient and remainder[DW-1:0], pulse done=1 for one en cycle, and return to IDLE.
REQ-019 DONE_Z: the block SHALL set quotient=all ones, remainder=dividend[DW-1:0], div_by_zero=1, pulse done=1, and return to IDLE.
REQ-020 Latency: with start accepted at edge t and en held high, done SHALL be high in the cycle after edge t+NW+1 (normal) or after edge t+1 (divide-by-zero).
REQ-021 quotient, remainder and div_by_zero SHALL hold their values until the next accepted start.
REQ-022 start while busy=1 SHALL be ignored; operand changes while busy SHALL have no effect.
REQ-023 start SHALL be accepted in the cycle following done (back-to-back operation).
REQ-024 en=0 in any state SHALL freeze the FSM, counter, datapath and outputs, including a pending done pulse.
REQ-025 Arithmetic SHALL be unsigned; the result SHALL satisfy dividend == quotient*divisor + remainder, with remainder < divisor.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, and clear the counter and internal registers.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first accepted start after release SHALL begin a fresh division.

Structure
REQ-028 The shared package SHALL hold the NW/DW defaults, the FSM state typedef (IDLE, RUN, DONE_Z, FIN) and the counter width constant.
REQ-029 The trial subtraction SHALL be a single sub-module, sub_cla, which is a (DW+1)-bit carry-lookahead subtractor with outputs diff and borrow; all other logic SHALL stay in div512_ss.

Verification
REQ-030 dividend=100, divisor=7, en=1 -> done exactly NW+1 cycles after start; quotient=14, remainder=2, div_by_zero=0.
REQ-031 dividend=all ones (NW), divisor=1 -> quotient=all ones, remainder=0; and dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-032 divisor=0, dividend=0x1234 -> done 1 cycle after start; quotient=all ones, remainder=0x1234, div_by_zero=1.
REQ-033 start re-pulsed with new operands at cycle 100 of RUN -> ignored; the result matches the first operands, and busy stays high.
REQ-034 en toggled 50% randomly during RUN -> same result as with en=1; done arrives after NW+1 enabled cycles.
REQ-035 rst_n pulsed low at cycle 300 of RUN -> all outputs 0 at once, no done pulse; a new start (1000/10) -> quotient=100, remainder=0.
